// File: rtl/adc_rx_pkg.sv
// Shared types and widths for the SAR ADC half-word receiver.
package adc_rx_pkg;

    localparam int HALF_W = 6;
    localparam int CODE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HIGH
    } rx_state_t;

endpackage

// File: rtl/adc_rx_sync.sv
// N-stage synchroniser for a W-bit vector; every bit sees the same latency.
module adc_rx_sync #(
    parameter int N = 2,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [N-1:0][W-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_reg <= '0;
        end else begin
            chain_reg[0] <= d;
            for (int i = 1; i < N; i++) begin
                chain_reg[i] <= chain_reg[i-1];
            end
        end
    end

    assign q = chain_reg[N-1];

endmodule

// File: rtl/adc_data_receiver.sv
// Oversampling receiver: reassembles inverted 6-bit half-words into 12-bit codes
// and presents them on a ready/valid port with framing-error and overrun flags.
module adc_data_receiver
    import adc_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2,
    parameter int MIN_HIGH    = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HALF_W-1:0] adc_data,
    input  logic              adc_clk_data,
    output logic [CODE_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              frame_err,
    output logic              overrun,
    input  logic              clear_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int HCNT_W = $clog2(MIN_HIGH + 1);
    localparam logic [HCNT_W-1:0] SETTLE_C   = HCNT_W'(SETTLE);
    localparam logic [HCNT_W-1:0] MIN_HIGH_C = HCNT_W'(MIN_HIGH);

    logic [HALF_W-1:0] sync_data;
    logic              sync_strobe;
    logic [HALF_W-1:0] d_prev_reg;
    logic              strobe_prev_reg;

    rx_state_t         state_reg, state_next;
    logic [HCNT_W-1:0] hcnt_reg, hcnt_next;
    logic [HALF_W-1:0] msb_reg, msb_next;
    logic              deliver;
    logic              frame_err_next;

    logic [CODE_W-1:0] result_reg;
    logic              result_valid_reg;
    logic              frame_err_reg;
    logic              overrun_reg;
    logic [CNT_W-1:0]  frame_cnt_reg;

    adc_rx_sync #(
        .N (SYNC_STAGES),
        .W (HALF_W + 1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({adc_clk_data, adc_data}),
        .q   ({sync_strobe, sync_data})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            hcnt_reg        <= '0;
            msb_reg         <= '0;
            d_prev_reg      <= '0;
            strobe_prev_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hcnt_reg        <= hcnt_next;
            msb_reg         <= msb_next;
            d_prev_reg      <= sync_data;
            strobe_prev_reg <= sync_strobe;
        end
    end

    // The LSB half is taken from d_prev: on the fall cycle the bus has already
    // reverted to the MSB half, so the previous sample is the last valid one.
    always_comb begin
        state_next     = state_reg;
        hcnt_next      = hcnt_reg;
        msb_next       = msb_reg;
        deliver        = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sync_strobe && !strobe_prev_reg) begin
                    state_next = ST_SETTLE;
                    hcnt_next  = HCNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!sync_strobe) begin
                    state_next     = ST_IDLE;
                    frame_err_next = 1'b1;
                end else begin
                    hcnt_next = hcnt_reg + HCNT_W'(1);
                    if (hcnt_reg == SETTLE_C) begin
                        msb_next   = ~sync_data;
                        state_next = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                if (!sync_strobe) begin
                    state_next = ST_IDLE;
                    if (hcnt_reg >= MIN_HIGH_C) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else if (hcnt_reg < MIN_HIGH_C) begin
                    hcnt_next = hcnt_reg + HCNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Holding register: a word may load in the same cycle the old one is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            overrun_reg      <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            frame_err_reg <= frame_err_next;
            if (deliver && (!result_valid_reg || result_ready)) begin
                result_reg       <= {msb_reg, ~d_prev_reg};
                result_valid_reg <= 1'b1;
                frame_cnt_reg    <= frame_cnt_reg + CNT_W'(1);
            end else if (result_valid_reg && result_ready) begin
                result_valid_reg <= 1'b0;
            end
            if (deliver && result_valid_reg && !result_ready) begin
                overrun_reg <= 1'b1;
            end else if (clear_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign frame_err    = frame_err_reg;
    assign overrun      = overrun_reg;
    assign frame_cnt    = frame_cnt_reg;

endmodule

// File: tb/tb_adc_data_receiver.sv
// Directed bench for adc_data_receiver; the DUT uses a 4-bit frame counter so
// the wrap from all-ones to zero is reached in a handful of frames.
module tb_adc_data_receiver;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       adc_data;
    logic             adc_clk_data;
    logic [11:0]      result;
    logic             result_valid;
    logic             result_ready;
    logic             frame_err;
    logic             overrun;
    logic             clear_err;
    logic [CNT_W-1:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    adc_data_receiver #(
        .SYNC_STAGES (2),
        .SETTLE      (2),
        .MIN_HIGH    (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_clk_data (adc_clk_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .clear_err    (clear_err),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe high for 'high' cycles: MSB half for 3 cycles, then LSB half; then
    // one strobe-low cycle with the bus back on the MSB half.
    task automatic frame(input logic [11:0] code, input int high);
        logic [5:0] msb_inv;
        logic [5:0] lsb_inv;
        msb_inv = ~code[11:6];
        lsb_inv = ~code[5:0];
        for (int i = 0; i < high; i++) begin
            adc_clk_data = 1'b1;
            adc_data     = (i < 3) ? msb_inv : lsb_inv;
            tick(1);
        end
        adc_clk_data = 1'b0;
        adc_data     = msb_inv;
        tick(1);
        $display("frame code=%03h high=%0d", code, high);
    endtask

    task automatic consume();
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        check("valid_after_consume", 32'(result_valid), 32'd0);
    endtask

    initial begin
        logic [11:0] code;
        rst          = 1'b1;
        adc_data     = '0;
        adc_clk_data = 1'b0;
        result_ready = 1'b0;
        clear_err    = 1'b0;
        tick(3);
        check("rst_result", 32'(result), 32'h0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        tick(1);

        // Basic frame, including latency from strobe fall to valid
        frame(12'hA5C, 20);
        tick(1);
        check("a5c_valid_early", 32'(result_valid), 32'd0);
        tick(1);
        check("a5c_valid", 32'(result_valid), 32'd1);
        check("a5c_result", 32'(result), 32'hA5C);
        check("a5c_cnt", 32'(frame_cnt), 32'd1);
        consume();

        // Too short for SETTLE, then too short for MIN_HIGH
        frame(12'h123, 2);
        tick(2);
        check("short2_err", 32'(frame_err), 32'd1);
        tick(1);
        check("short2_err_pulse", 32'(frame_err), 32'd0);
        frame(12'h456, 3);
        tick(2);
        check("short3_err", 32'(frame_err), 32'd1);
        tick(1);
        check("short3_err_pulse", 32'(frame_err), 32'd0);
        check("short_valid", 32'(result_valid), 32'd0);
        check("short_cnt", 32'(frame_cnt), 32'd1);

        // Overrun with the consumer stalled, then clear
        frame(12'h000, 6);
        tick(2);
        check("w000_valid", 32'(result_valid), 32'd1);
        check("w000_result", 32'(result), 32'h000);
        check("w000_cnt", 32'(frame_cnt), 32'd2);
        frame(12'hFFF, 6);
        tick(2);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_result_held", 32'(result), 32'h000);
        check("ovr_valid_held", 32'(result_valid), 32'd1);
        check("ovr_cnt", 32'(frame_cnt), 32'd2);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        consume();

        // Handshake in the delivery cycle of the next word
        frame(12'h3C5, 6);
        tick(2);
        check("w3c5_result", 32'(result), 32'h3C5);
        check("w3c5_cnt", 32'(frame_cnt), 32'd3);
        frame(12'h0A7, 6);
        tick(1);
        check("w3c5_stable", 32'(result), 32'h3C5);
        result_ready = 1'b1;
        tick(1);
        check("w0a7_result", 32'(result), 32'h0A7);
        check("w0a7_valid", 32'(result_valid), 32'd1);
        check("w0a7_overrun", 32'(overrun), 32'd0);
        check("w0a7_cnt", 32'(frame_cnt), 32'd4);
        tick(1);
        result_ready = 1'b0;
        check("w0a7_drop", 32'(result_valid), 32'd0);

        // Back-to-back frames with a single idle strobe-low cycle
        frame(12'h111, 6);
        frame(12'h222, 6);
        tick(1);
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
        check("b2b_result", 32'(result), 32'h222);
        check("b2b_valid", 32'(result_valid), 32'd1);
        check("b2b_overrun", 32'(overrun), 32'd0);
        check("b2b_cnt", 32'(frame_cnt), 32'd6);

        // Reset in the middle of a frame
        adc_clk_data = 1'b1;
        adc_data     = 6'h3E;
        tick(6);
        rst          = 1'b1;
        adc_clk_data = 1'b0;
        adc_data     = '0;
        tick(1);
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_cnt", 32'(frame_cnt), 32'd0);
        tick(2);
        check("midrst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick(2);
        check("midrst_no_err", 32'(frame_err), 32'd0);
        frame(12'h5A3, 8);
        tick(2);
        check("w5a3_result", 32'(result), 32'h5A3);
        check("w5a3_valid", 32'(result_valid), 32'd1);
        check("w5a3_cnt", 32'(frame_cnt), 32'd1);
        consume();

        // Counter wrap: 14 more frames reach all-ones, the next one wraps
        for (int k = 0; k < 14; k++) begin
            code = 12'(k * 293 + 7);
            frame(code, 5);
            tick(2);
            check("wrap_fill_result", 32'(result), 32'(code));
            consume();
        end
        check("cnt_all_ones", 32'(frame_cnt), 32'hF);
        frame(12'h9C6, 5);
        tick(2);
        check("wrap_result", 32'(result), 32'h9C6);
        check("wrap_valid", 32'(result_valid), 32'd1);
        check("wrap_cnt", 32'(frame_cnt), 32'd0);
        check("wrap_overrun", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
